// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared constants and helper functions for the programmable serial
// pattern detector (seq_det_prog) and its shift-window sub-module.
//   DEF_PAT_W / DEF_CNT_W : default pattern and counter widths
//   MAX_W                 : widest vector the helper functions accept
//   clamp_len()           : folds a requested pattern length into 1..max
//   low_bits_eq()         : equality of the low n bits of two vectors
//   sat_inc()             : increment that sticks at the all-ones value
package seq_det_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

  // Helpers work on fixed 64-bit vectors; callers zero-extend into them,
  // so PAT_W and CNT_W must stay below 64.
  localparam int MAX_W = 64;

  // Length 0 makes no sense for a pattern, so it behaves as length 1;
  // anything beyond the window is cut down to the window size.
  function automatic int clamp_len(input int len, input int max_len);
    int res;
    res = len;
    if (len < 1) begin
      res = 1;
    end else if (len > max_len) begin
      res = max_len;
    end
    return res;
  endfunction

  // True when bits [n-1:0] of a and b agree; higher bits are don't-care.
  function automatic logic low_bits_eq(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int n);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < n) && (a[i] != b[i])) begin
        eq = 1'b0;
      end
    end
    return eq;
  endfunction

  // Increment a w-bit value held in a MAX_W vector, saturating at 2^w-1.
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                               input int w);
    logic [MAX_W-1:0] top;
    top = (MAX_W'(1) << w) - MAX_W'(1);
    return (v >= top) ? v : v + MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// seq_det_window
// History shift register plus fill counter for the pattern detector.
// Each shifted bit enters at hist[0]; fill counts how many valid bits are
// in the window (saturating at PAT_W). match is combinational and reflects
// the window as it will look after this cycle's shift.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : empty the window (pattern reload)
//   shift      : shift data into the window this cycle
//   data       : serial bit to shift in
//   pat, len   : active pattern and its (already clamped) length
//   consume    : on a match, empty the fill count (non-overlapping mode)
//   match      : the bit being shifted in completes the pattern
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             data,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic             consume,
  output logic             match
);

  logic [PAT_W-1:0] hist_reg;
  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_reg;
  logic [LEN_W-1:0] fill_next;

  always_comb begin
    hist_next = {hist_reg[PAT_W-2:0], data};
    fill_next = (fill_reg >= LEN_W'(PAT_W)) ? fill_reg : fill_reg + 1'b1;
    // Stale history bits beyond fill are excluded by the fill >= len test,
    // which is why consuming a match only needs to reset fill.
    match = shift && (fill_next >= len) &&
            low_bits_eq(MAX_W'(hist_next), MAX_W'(pat), int'(len));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (clr) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (shift) begin
      hist_reg <= hist_next;
      fill_reg <= (match && consume) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog
// Programmable serial bit-pattern detector. Compares the most recent
// len bits of the serial stream against a runtime-loaded pattern and
// pulses out for one cycle per match; keeps a saturating match count.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : in is sampled this cycle
//   in         : serial data bit
//   pat_load   : latch pat / pat_len (wins over sampling)
//   pat        : pattern, pat[pat_len-1] oldest bit, pat[0] newest
//   pat_len    : active pattern length (0 -> 1, >PAT_W -> PAT_W)
//   overlap    : 1 = overlapping detection, 0 = non-overlapping
//   cnt_clr    : clear match counter (wins over increment)
//   out        : one-cycle registered match pulse
//   match_cnt  : saturating match count
//   armed      : a pattern has been loaded since reset
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic             armed_reg;
  logic             out_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             shift;
  logic             match;

  // A load cycle discards the incoming bit; nothing is sampled until armed.
  assign shift = in_valid && armed_reg && !pat_load;

  seq_det_window #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pat_load),
    .shift   (shift),
    .data    (in),
    .pat     (pat_reg),
    .len     (len_reg),
    .consume (!overlap),
    .match   (match)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_reg   <= '0;
      len_reg   <= LEN_W'(1);
      armed_reg <= 1'b0;
      out_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      if (pat_load) begin
        pat_reg   <= pat;
        len_reg   <= LEN_W'(clamp_len(int'(pat_len), PAT_W));
        armed_reg <= 1'b1;
      end
      out_reg <= match;
      if (cnt_clr) begin
        cnt_reg <= '0;
      end else if (match) begin
        cnt_reg <= CNT_W'(sat_inc(MAX_W'(cnt_reg), CNT_W));
      end
    end
  end

  assign out       = out_reg;
  assign match_cnt = cnt_reg;
  assign armed     = armed_reg;

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog
// Directed, table-driven bench for seq_det_prog. A second instance with a
// 2-bit counter shares all inputs and is checked in the saturation rows.
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       din;
  logic       pat_load;
  logic [7:0] pat;
  logic [3:0] pat_len;
  logic       overlap;
  logic       cnt_clr;
  logic       out;
  logic [7:0] match_cnt;
  logic       armed;
  logic       out2;
  logic [1:0] match_cnt2;
  logic       armed2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_det_prog dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (din),
    .pat_load  (pat_load),
    .pat       (pat),
    .pat_len   (pat_len),
    .overlap   (overlap),
    .cnt_clr   (cnt_clr),
    .out       (out),
    .match_cnt (match_cnt),
    .armed     (armed)
  );

  seq_det_prog #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (din),
    .pat_load  (pat_load),
    .pat       (pat),
    .pat_len   (pat_len),
    .overlap   (overlap),
    .cnt_clr   (cnt_clr),
    .out       (out2),
    .match_cnt (match_cnt2),
    .armed     (armed2)
  );

  typedef struct {
    logic       rstn;
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       clr;
    logic       valid;
    logic       din;
    logic       eout;
    logic [7:0] ecnt;
    logic       earm;
    logic       chk2;
    logic [1:0] ecnt2;
  } vec_t;

  vec_t vq[$];
  logic tb_ovl = 1'b0;
  logic tb_arm = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic rstn, input logic load, input logic [7:0] p,
                      input logic [3:0] len, input logic ovl, input logic clr,
                      input logic valid, input logic d, input logic eout,
                      input logic [7:0] ecnt, input logic earm, input logic chk2,
                      input logic [1:0] ecnt2);
    vec_t v;
    v.rstn = rstn; v.load = load; v.pat = p; v.len = len; v.ovl = ovl;
    v.clr = clr; v.valid = valid; v.din = d; v.eout = eout; v.ecnt = ecnt;
    v.earm = earm; v.chk2 = chk2; v.ecnt2 = ecnt2;
    vq.push_back(v);
  endtask

  task automatic rst_row();
    tb_arm = 1'b0;
    push(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'd0);
  endtask

  task automatic load_row(input logic [7:0] p, input logic [3:0] len, input logic ovl,
                          input logic clr, input logic valid, input logic d,
                          input logic [7:0] ecnt);
    tb_ovl = ovl;
    tb_arm = 1'b1;
    push(1'b1, 1'b1, p, len, ovl, clr, valid, d, 1'b0, ecnt, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic bit_row(input logic d, input logic eout, input logic [7:0] ecnt);
    push(1'b1, 1'b0, 8'h00, 4'd0, tb_ovl, 1'b0, 1'b1, d, eout, ecnt, tb_arm, 1'b0, 2'd0);
  endtask

  task automatic gap_row(input logic [7:0] ecnt);
    push(1'b1, 1'b0, 8'h00, 4'd0, tb_ovl, 1'b0, 1'b0, 1'b1, 1'b0, ecnt, tb_arm, 1'b0, 2'd0);
  endtask

  task automatic sat_row(input logic clr, input logic d, input logic eout,
                         input logic [7:0] ecnt, input logic [1:0] ecnt2);
    push(1'b1, 1'b0, 8'h00, 4'd0, tb_ovl, clr, 1'b1, d, eout, ecnt, tb_arm, 1'b1, ecnt2);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst_n = v.rstn; pat_load = v.load; pat = v.pat; pat_len = v.len;
    overlap = v.ovl; cnt_clr = v.clr; in_valid = v.valid; din = v.din;
    @(posedge clk);
    #1;
  endtask

  // Hand-written stepping for the overlap-toggle sequence.
  task automatic step(input logic d, input logic ovl, input logic eout,
                      input logic [7:0] ecnt, input string name);
    vec_t v;
    v.rstn = 1'b1; v.load = 1'b0; v.pat = 8'h00; v.len = 4'd0; v.ovl = ovl;
    v.clr = 1'b0; v.valid = 1'b1; v.din = d; v.eout = eout; v.ecnt = ecnt;
    v.earm = 1'b1; v.chk2 = 1'b0; v.ecnt2 = 2'd0;
    drive(v);
    check({name, "_out"}, 32'(out), 32'(eout));
    check({name, "_cnt"}, 32'(match_cnt), 32'(ecnt));
    $display("seq %s in=%b ovl=%b out=%b cnt=%0d", name, d, ovl, out, match_cnt);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; din = 1'b0; pat_load = 1'b0;
    pat = 8'h00; pat_len = 4'd0; overlap = 1'b0; cnt_clr = 1'b0;

    // Reset state
    rst_row();
    // Reference stream 0101101010, overlap: pulses after bits 3, 6, 8
    load_row(8'b101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 1, 1);
    bit_row(1, 0, 1); bit_row(0, 0, 1); bit_row(1, 1, 2); bit_row(0, 0, 2);
    bit_row(1, 1, 3); bit_row(0, 0, 3);
    // Same stream, non-overlap: pulses after bits 3 and 6
    load_row(8'b101, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 1, 1);
    bit_row(1, 0, 1); bit_row(0, 0, 1); bit_row(1, 1, 2); bit_row(0, 0, 2);
    bit_row(1, 0, 2); bit_row(0, 0, 2);
    // Seven ones, 1111 overlap: four back-to-back pulses
    load_row(8'b1111, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    bit_row(1, 0, 0); bit_row(1, 0, 0); bit_row(1, 0, 0); bit_row(1, 1, 1);
    bit_row(1, 1, 2); bit_row(1, 1, 3); bit_row(1, 1, 4);
    // Seven ones, non-overlap: single pulse
    load_row(8'b1111, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    bit_row(1, 0, 0); bit_row(1, 0, 0); bit_row(1, 0, 0); bit_row(1, 1, 1);
    bit_row(1, 0, 1); bit_row(1, 0, 1); bit_row(1, 0, 1);
    // Reference stream with idle gaps
    load_row(8'b101, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    bit_row(0, 0, 0); gap_row(0); bit_row(1, 0, 0); gap_row(0); gap_row(0);
    bit_row(0, 0, 0); bit_row(1, 1, 1); gap_row(1); gap_row(1); gap_row(1);
    bit_row(1, 0, 1); bit_row(0, 0, 1); gap_row(1); bit_row(1, 1, 2);
    bit_row(0, 0, 2); gap_row(2); bit_row(1, 1, 3); gap_row(3); bit_row(0, 0, 3);
    // Load with in_valid=1, in=1: that bit must be dropped
    load_row(8'b101, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
    bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 1, 1);
    // pat_len=0 acts as length 1 (pattern "1"), non-overlap
    load_row(8'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    bit_row(0, 0, 0); bit_row(1, 1, 1); bit_row(0, 0, 1); bit_row(1, 1, 2);
    bit_row(1, 1, 3);
    // pat_len=15 clamps to 8: pattern A5 fed oldest bit first
    load_row(8'hA5, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(0, 0, 0);
    bit_row(0, 0, 0); bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 1, 1);
    bit_row(0, 0, 1);
    // Saturation of the 2-bit counter, then clear on a match cycle
    tb_ovl = 1'b1; tb_arm = 1'b1;
    push(1'b1, 1'b1, 8'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 2'd0);
    sat_row(0, 1, 1, 1, 1); sat_row(0, 1, 1, 2, 2); sat_row(0, 1, 1, 3, 3);
    sat_row(0, 1, 1, 4, 3); sat_row(0, 1, 1, 5, 3);
    sat_row(1, 1, 1, 0, 0);
    sat_row(0, 0, 0, 0, 0);
    // Reset mid-stream after "10", then ignored samples, then reload
    load_row(8'b101, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    bit_row(1, 0, 0); bit_row(0, 0, 0);
    rst_row();
    bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 0, 0);
    load_row(8'b101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    bit_row(1, 0, 0); bit_row(0, 0, 0); bit_row(1, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      check($sformatf("v%0d_out", i), 32'(out), 32'(vq[i].eout));
      check($sformatf("v%0d_cnt", i), 32'(match_cnt), 32'(vq[i].ecnt));
      check($sformatf("v%0d_armed", i), 32'(armed), 32'(vq[i].earm));
      if (vq[i].chk2) begin
        check($sformatf("v%0d_cnt2", i), 32'(match_cnt2), 32'(vq[i].ecnt2));
        check($sformatf("v%0d_out2", i), 32'(out2), 32'(vq[i].eout));
        check($sformatf("v%0d_armed2", i), 32'(armed2), 32'(vq[i].earm));
      end
      $display("vec %0d rst_n=%b load=%b valid=%b in=%b out=%b cnt=%0d armed=%b",
               i, vq[i].rstn, vq[i].load, vq[i].valid, vq[i].din, out, match_cnt, armed);
    end

    // Overlap toggled mid-stream: takes effect at the next match decision
    begin
      vec_t v;
      v.rstn = 1'b1; v.load = 1'b1; v.pat = 8'b101; v.len = 4'd3; v.ovl = 1'b1;
      v.clr = 1'b1; v.valid = 1'b0; v.din = 1'b0; v.eout = 1'b0; v.ecnt = 8'd0;
      v.earm = 1'b1; v.chk2 = 1'b0; v.ecnt2 = 2'd0;
      drive(v);
      check("tog_load_cnt", 32'(match_cnt), 32'd0);
    end
    step(1, 1, 0, 0, "tog_b0");
    step(0, 1, 0, 0, "tog_b1");
    step(1, 1, 1, 1, "tog_b2");
    step(0, 1, 0, 1, "tog_b3");
    step(1, 1, 1, 2, "tog_b4");
    step(0, 0, 0, 2, "tog_b5");
    step(1, 0, 1, 3, "tog_b6");
    step(0, 0, 0, 3, "tog_b7");
    step(1, 0, 0, 3, "tog_b8");
    step(0, 0, 0, 3, "tog_b9");
    step(1, 0, 1, 4, "tog_b10");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable serial bit-pattern detector: the parametrised successor to the fixed-pattern `seq_det`. It samples one serial bit per qualified clock and compares the most recent `pat_len` bits against a runtime-loaded pattern. It pulses `out` on each match, with overlapping or non-overlapping detection selectable. A saturating match counter is kept for status readback. It sits on the serial input path in the same place `seq_det` does.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: match counter width.
- `LEN_W`, $clog2(PAT_W+1): width of `pat_len` (derived; not overridden).

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: `in` is sampled this cycle.
- `in` input 1: serial data bit.
- `pat_load` input 1: latch `pat` and `pat_len` this cycle.
- `pat` input PAT_W: pattern; `pat[pat_len-1]` is the oldest (first-received) bit, `pat[0]` the newest.
- `pat_len` input LEN_W: active pattern length.
- `overlap` input 1: 1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- `cnt_clr` input 1: clear match counter.
- `out` output 1: one-cycle match pulse.
- `match_cnt` output CNT_W: saturating count of matches.
- `armed` output 1: a pattern has been loaded since reset.

## Operation
- **State:** history shift register `hist[PAT_W-1:0]`, fill counter `fill` (0..PAT_W), pattern register `pat_r`, length register `len_r`, `armed`.
- **Load:** when `pat_load`=1:
  - `pat_r`←`pat`.
  - `len_r`←clamp(`pat_len`): 0→1, >PAT_W→PAT_W.
  - `hist`←0, `fill`←0, `armed`←1.
  - `in` is discarded that cycle even if `in_valid`=1. Load has priority over sampling.
- **Sample:** when `in_valid`=1, `pat_load`=0 and `armed`=1:
  - `hist`←{`hist[PAT_W-2:0]`, `in`}.
  - `fill`←min(`fill`+1, PAT_W).
- **Match condition:** evaluated on the post-shift values. `fill_next` ≥ `len_r` and the low `len_r` bits of `hist_next` equal the low `len_r` bits of `pat_r`.
- **On match:**
  - `out`←1.
  - `match_cnt` increments and saturates at 2^CNT_W−1.
  - If `overlap`=0, `fill`←0, so the bits just matched cannot be reused. `hist` is left as is; it is masked by `fill`.
  - If `overlap`=1, `fill` is left alone.
- **Not armed:** `in_valid` is ignored; `out` stays 0.
- **Idle cycles** (`in_valid`=0): `hist` and `fill` hold; `out`←0.
- **Counter clear:** `cnt_clr`=1 forces `match_cnt`←0. This wins over a simultaneous increment. `out` still pulses.
- **Reset** (`rst_n`=0 at an edge): `out`=0, `match_cnt`=0, `armed`=0, `hist`=0, `fill`=0, `pat_r`=0, `len_r`=1.
  - Reset mid-stream discards all partial history.

## Timing
- **`out` latency:** registered. It is high for exactly the one cycle following the edge that samples the completing bit, i.e. zero extra cycles after the sampling edge.
- **Back-to-back matches:** possible in overlap mode. `out` stays high on consecutive cycles, one match per sampled bit.
- **`match_cnt`:** updates on the same edge that `out` rises.
- **Pattern-change latency:** a new pattern takes effect on bits sampled from the edge after `pat_load`.
- **First possible match:** after `len_r` valid samples following the load.
- **`overlap` toggling mid-stream:** takes effect at the next match decision. There is no flush.

## Structure
- **Package `seq_det_pkg`:**
  - default `PAT_W`/`CNT_W` constants;
  - length-clamp function;
  - masked-compare function (low-n-bits equality);
  - saturating-increment function.
- **Sub-module `seq_det_window`:** `hist`+`fill` shift window with clear and match-consume inputs, and a `match` output.
- **Top level:** configuration registers, counter, and output register.

## Test plan
- **Reference stream, overlap:** `pat`=3'b101, `pat_len`=3, `overlap`=1; stream 0,1,0,1,1,0,1,0,1,0 on consecutive cycles → `out` pulses after bits 3, 6, 8 (0-indexed); `match_cnt`=3.
- **Same stream, non-overlap:** `overlap`=0 → pulses after bits 3 and 6 only; `match_cnt`=2.
- **Run of ones, overlap:** `pat`=4'b1111, len 4, overlap=1; seven consecutive 1s → pulses after bits 3, 4, 5, 6 (four back-to-back cycles).
  - Repeat with overlap=0 → one pulse, after bit 3.
- **Gapped input and load priority:**
  - Same stream as the first case, with `in_valid`=0 gaps of 1–3 cycles → identical pulse pattern relative to valid bits.
  - Assert `pat_load` together with `in_valid`=1 → that bit is ignored.
  - `pat_len`=0 → behaves as length 1.
- **Saturation and clear:**
  - CNT_W=2, five matches → `match_cnt` holds at 3.
  - `cnt_clr` on a match cycle → `match_cnt`=0 and `out`=1.
- **Reset mid-operation:**
  - Drop `rst_n` after two bits of 101 → all outputs 0, `armed`=0; samples are ignored until a reload.
  - After reload, a full 101 is required to match.
